// File: rtl/pb_multislot_pkg.sv
// Shared types and sizing helpers for the multi-slot packet buffer.
// Receive/send state encodings live here so the top and bench agree.
package pb_multislot_pkg;

  typedef enum logic {
    R_IDLE,
    R_RECV
  } rx_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SEND,
    S_DONE
  } tx_state_e;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_ROUTE_W = 24;
  localparam int DEF_SLOTS   = 4;
  localparam int DEF_SLOT_AW = 8;
  localparam int DEF_NBR_W   = 2;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/packet_buffer_multislot_if.sv
// Upstream push and downstream pull bundles of the packet buffer.
// The push side is driven by the core; the pull side by the buffer.
interface pb_push_if #(
  parameter int DATA_W  = 64,
  parameter int ROUTE_W = 24
);
  logic [DATA_W-1:0]  in_data;
  logic [ROUTE_W-1:0] in_pkt_route;
  logic               in_wr;
  logic               in_req;
  logic               in_ack;
  logic               in_empty;

  modport master (
    output in_data, in_pkt_route, in_wr, in_req,
    input  in_ack, in_empty
  );
  modport slave (
    input  in_data, in_pkt_route, in_wr, in_req,
    output in_ack, in_empty
  );
endinterface

interface pb_pull_if #(
  parameter int DATA_W  = 64,
  parameter int ROUTE_W = 24,
  parameter int NBR_W   = 2
);
  logic [DATA_W-1:0]  out_data;
  logic [ROUTE_W-1:0] out_pkt_route;
  logic [NBR_W-1:0]   out_neighbor;
  logic               out_bypass;
  logic               out_wr;
  logic               out_bop;
  logic               out_eop;
  logic               out_req;
  logic               out_ack;
  logic               out_rdy;

  modport master (
    output out_data, out_pkt_route, out_neighbor, out_bypass,
    output out_wr, out_bop, out_eop, out_req,
    input  out_ack, out_rdy
  );
  modport slave (
    input  out_data, out_pkt_route, out_neighbor, out_bypass,
    input  out_wr, out_bop, out_eop, out_req,
    output out_ack, out_rdy
  );
endinterface

// File: rtl/pb_slot_queue.sv
// Slot bookkeeping: free bitmap, lowest-free pick, and the
// arrival-order FIFO of committed {slot, length} entries.
module pb_slot_queue #(
  parameter int SLOTS = 4,
  parameter int SW    = 2,
  parameter int LW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic          rx_free,
  input  logic [SW-1:0] rx_slot,
  input  logic          push,
  input  logic [LW-1:0] push_len,
  input  logic          pop,
  input  logic          rel,
  input  logic [SW-1:0] rel_slot,
  output logic          free_any,
  output logic [SW-1:0] low_free,
  output logic          q_empty,
  output logic [SW-1:0] head_slot,
  output logic [LW-1:0] head_len
);

  logic [SLOTS-1:0] busy;
  logic [SW-1:0]    q_slot [SLOTS];
  logic [LW-1:0]    q_len  [SLOTS];
  logic [SW-1:0]    wp, rp;
  logic [SW:0]      cnt;

  always_comb begin
    low_free = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (!busy[i]) low_free = SW'(i);
  end

  assign free_any  = ~&busy;
  assign q_empty   = (cnt == '0);
  assign head_slot = q_slot[rp];
  assign head_len  = q_len[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (alloc)   busy[low_free] <= 1'b1;
      if (rx_free) busy[rx_slot]  <= 1'b0;
      if (rel)     busy[rel_slot] <= 1'b0;
    end
  end

  // Pointers wrap naturally because SLOTS is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        q_slot[wp] <= rx_slot;
        q_len[wp]  <= push_len;
        wp         <= wp + SW'(1);
      end
      if (pop) rp <= rp + SW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/packet_buffer_multislot.sv
// Multi-slot store-and-forward packet buffer with route decode,
// overflow drop, zero-length discard and occupancy status.
module packet_buffer_multislot
  import pb_multislot_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ROUTE_W     = DEF_ROUTE_W,
  parameter int SLOTS       = DEF_SLOTS,
  parameter int SLOT_AW     = DEF_SLOT_AW,
  parameter int NBR_W       = DEF_NBR_W,
  parameter int BYPASS_BIT  = 5,
  parameter int ROUTE_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  pb_push_if.slave                  up,
  pb_pull_if.master                 dn,
  output logic [cnt_w(SLOTS)-1:0]   pkt_count,
  output logic [15:0]               drop_count
);

  localparam int SW = $clog2(SLOTS);
  localparam int LW = SLOT_AW + 1;
  localparam int AW = SW + SLOT_AW;
  localparam int CW = cnt_w(SLOTS);
  localparam logic [LW-1:0] FULL = LW'(depth_of(SLOT_AW));
  localparam logic [LW-1:0] ONE  = LW'(1);

  logic [DATA_W-1:0]  mem  [2**AW];
  logic [ROUTE_W-1:0] meta [SLOTS];

  rx_state_e     r_st;
  logic [SW-1:0] r_slot;
  logic [LW-1:0] wlen;
  logic          ovf;

  tx_state_e     s_st;
  logic [SW-1:0] s_slot;
  logic [LW-1:0] s_len;
  logic [LW-1:0] rptr;

  logic          free_any, q_empty;
  logic [SW-1:0] low_free, head_slot;
  logic [LW-1:0] head_len;
  logic          alloc, rx_done, rx_free, push, wr_en;
  logic          pop, issue, rel;
  logic [ROUTE_W-1:0] head_route;

  assign alloc   = (r_st == R_IDLE) && up.in_req && free_any;
  assign rx_done = (r_st == R_RECV) && !up.in_req;
  assign push    = rx_done && (wlen != '0) && !ovf;
  assign rx_free = rx_done && ((wlen == '0) || ovf);
  assign wr_en   = (r_st == R_RECV) && up.in_req && up.in_wr
                   && (wlen != FULL);

  assign pop   = (s_st == S_IDLE) && !q_empty;
  assign issue = (s_st == S_SEND) && dn.out_rdy && (rptr != s_len);
  assign rel   = (s_st == S_DONE) && !dn.out_ack;

  assign up.in_ack   = alloc || (r_st == R_RECV);
  assign up.in_empty = (r_st == R_IDLE) && free_any;
  assign head_route  = meta[head_slot];

  pb_slot_queue #(.SLOTS(SLOTS), .SW(SW), .LW(LW)) u_q (
    .clk      (clk),
    .reset    (reset),
    .alloc    (alloc),
    .rx_free  (rx_free),
    .rx_slot  (r_slot),
    .push     (push),
    .push_len (wlen),
    .pop      (pop),
    .rel      (rel),
    .rel_slot (s_slot),
    .free_any (free_any),
    .low_free (low_free),
    .q_empty  (q_empty),
    .head_slot(head_slot),
    .head_len (head_len)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem[{r_slot, wlen[SLOT_AW-1:0]}] <= up.in_data;
    if (wr_en && (wlen == '0)) meta[r_slot] <= up.in_pkt_route;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st       <= R_IDLE;
      r_slot     <= '0;
      wlen       <= '0;
      ovf        <= 1'b0;
      drop_count <= '0;
    end else begin
      unique case (r_st)
        R_IDLE: if (alloc) begin
          r_st   <= R_RECV;
          r_slot <= low_free;
          wlen   <= '0;
          ovf    <= 1'b0;
        end
        R_RECV: if (!up.in_req) begin
          r_st <= R_IDLE;
          if (ovf && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
        end else if (up.in_wr) begin
          if (wr_en) wlen <= wlen + ONE;
          else       ovf  <= 1'b1;
        end
        default: r_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pkt_count <= '0;
    else unique case ({push, rel})
      2'b10:   pkt_count <= pkt_count + CW'(1);
      2'b01:   pkt_count <= pkt_count - CW'(1);
      default: pkt_count <= pkt_count;
    endcase
  end

  // Read data register doubles as out_data: one cycle after issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_st             <= S_IDLE;
      s_slot           <= '0;
      s_len            <= '0;
      rptr             <= '0;
      dn.out_data      <= '0;
      dn.out_pkt_route <= '0;
      dn.out_neighbor  <= '0;
      dn.out_bypass    <= 1'b0;
      dn.out_wr        <= 1'b0;
      dn.out_bop       <= 1'b0;
      dn.out_eop       <= 1'b0;
      dn.out_req       <= 1'b0;
    end else begin
      dn.out_wr  <= issue;
      dn.out_bop <= issue && (rptr == '0);
      dn.out_eop <= issue && (rptr == s_len - ONE);
      if (issue) dn.out_data <= mem[{s_slot, rptr[SLOT_AW-1:0]}];
      unique case (s_st)
        S_IDLE: if (pop) begin
          s_slot           <= head_slot;
          s_len            <= head_len;
          rptr             <= '0;
          dn.out_pkt_route <= head_route >> ROUTE_SHIFT;
          dn.out_neighbor  <= head_route[NBR_W-1:0];
          dn.out_bypass    <= head_route[BYPASS_BIT];
          dn.out_req       <= 1'b1;
          s_st             <= S_REQ;
        end
        S_REQ: if (dn.out_ack) s_st <= S_SEND;
        S_SEND: begin
          if (issue) rptr <= rptr + ONE;
          if (dn.out_eop) begin
            dn.out_req <= 1'b0;
            s_st       <= S_DONE;
          end
        end
        S_DONE: if (!dn.out_ack) s_st <= S_IDLE;
        default: s_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_buffer_multislot.sv
// Scoreboard bench for packet_buffer_multislot: directed packets with
// hand-computed route decode; a monitor checks every output word.
module tb_packet_buffer_multislot;

  typedef struct packed {
    logic [63:0] d;
    logic        bop;
    logic        eop;
    logic [1:0]  nbr;
    logic        byp;
    logic [23:0] rt;
  } exp_t;

  logic       clk = 0;
  logic       reset = 1;
  logic [2:0] pkt_count;
  logic [15:0] drop_count;

  int nvec = 0;
  int nbad = 0;
  int words_seen = 0;
  int eop_cnt = 0;
  int ack_eops = 0;
  bit ack_en = 0;
  bit rdy_toggle = 0;
  logic [3:0] rdy_pat = 4'b1001;
  int rdy_idx = 0;
  exp_t sb[$];

  pb_push_if #(.DATA_W(64), .ROUTE_W(24)) up ();
  pb_pull_if #(.DATA_W(64), .ROUTE_W(24), .NBR_W(2)) dn ();

  packet_buffer_multislot dut (
    .clk       (clk),
    .reset     (reset),
    .up        (up),
    .dn        (dn),
    .pkt_count (pkt_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Downstream port model: grant follows request, rdy optionally patterned.
  initial forever begin
    @(negedge clk);
    dn.out_ack = ack_en && dn.out_req;
    dn.out_rdy = rdy_toggle ? rdy_pat[rdy_idx % 4] : 1'b1;
    rdy_idx++;
  end

  initial forever begin
    exp_t e, a;
    @(negedge clk);
    if (dn.out_wr === 1'b1) begin
      words_seen++;
      if (dn.out_eop) eop_cnt++;
      a = '{dn.out_data, dn.out_bop, dn.out_eop, dn.out_neighbor,
            dn.out_bypass, dn.out_pkt_route};
      nvec++;
      if (sb.size() == 0) begin
        nbad++;
        $display("FAIL unexpected_word got=%h want=none", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          nbad++;
          $display("FAIL word got=%h want=%h", a, e);
        end
      end
    end
  end

  task automatic send_pkt(input logic [23:0] route, input int n,
                          input logic [63:0] base, input bit fwd,
                          input logic [1:0] nbr, input logic byp,
                          input logic [23:0] srt);
    int t = 0;
    exp_t e;
    up.in_req = 1;
    up.in_pkt_route = route;
    #1;
    while (!up.in_ack && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    ack_eops = eop_cnt;
    if (!up.in_ack) begin
      nvec++;
      nbad++;
      $display("FAIL ack_timeout got=0 want=1");
    end
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      up.in_wr = 1;
      up.in_data = base + 64'(i);
      if (fwd) begin
        e = '{base + 64'(i), i == 0, i == n - 1, nbr, byp, srt};
        sb.push_back(e);
      end
      @(negedge clk);
    end
    up.in_wr = 0;
    up.in_req = 0;
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((sb.size() != 0 || pkt_count != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_left"}, 64'(sb.size()), 64'd0);
    chk({nm, "_cnt0"}, 64'(pkt_count), 64'd0);
  endtask

  initial begin
    int w0;
    up.in_req = 0;
    up.in_wr = 0;
    up.in_data = '0;
    up.in_pkt_route = '0;
    dn.out_ack = 0;
    dn.out_rdy = 1;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({dn.out_req, dn.out_wr, dn.out_bop, dn.out_eop,
        dn.out_bypass, dn.out_neighbor, up.in_ack}), 64'd0);
    chk("rst_data", dn.out_data, 64'd0);
    chk("rst_route", 64'(dn.out_pkt_route), 64'd0);
    chk("rst_empty", 64'(up.in_empty), 64'd1);
    chk("rst_counts", 64'({pkt_count, drop_count}), 64'd0);
    reset = 0;
    ack_en = 1;

    // Single 4-word packet.
    w0 = words_seen;
    send_pkt(24'h000023, 4, 64'hA000_0000_0000_0000, 1, 2'd3, 1'b1, 24'h4);
    chk("t1_cnt1", 64'(pkt_count), 64'd1);
    drain("t1");
    chk("t1_words", 64'(words_seen - w0), 64'd4);

    // Fill all slots with the grant held off.
    ack_en = 0;
    send_pkt(24'h000011, 3, 64'hB100, 1, 2'd1, 1'b0, 24'h2);
    send_pkt(24'h0000A2, 2, 64'hB200, 1, 2'd2, 1'b1, 24'h14);
    send_pkt(24'h000007, 4, 64'hB300, 1, 2'd3, 1'b0, 24'h0);
    send_pkt(24'h00FFE0, 2, 64'hB400, 1, 2'd0, 1'b1, 24'h1FFC);
    chk("t2_cnt4", 64'(pkt_count), 64'd4);
    chk("t2_full", 64'(up.in_empty), 64'd0);
    fork
      send_pkt(24'h000039, 3, 64'hB500, 1, 2'd1, 1'b1, 24'h7);
      begin
        repeat (10) @(negedge clk);
        #2;
        chk("t2_noack", 64'(up.in_ack), 64'd0);
        ack_en = 1;
      end
    join
    chk("t2_ack_after_rel", 64'(ack_eops >= 1), 64'd1);
    drain("t2");

    // One-word packet, then an empty request.
    send_pkt(24'h000002, 1, 64'hC0DE, 1, 2'd2, 1'b0, 24'h0);
    drain("t3a");
    w0 = words_seen;
    send_pkt(24'h000003, 0, 64'h0, 0, 2'd0, 1'b0, 24'h0);
    chk("t3_zero_cnt", 64'(pkt_count), 64'd0);
    chk("t3_zero_empty", 64'(up.in_empty), 64'd1);
    repeat (8) @(negedge clk);
    chk("t3_zero_words", 64'(words_seen - w0), 64'd0);

    // Overflow drop, then a normal packet reuses the slot.
    send_pkt(24'h000010, 259, 64'hD000, 0, 2'd0, 1'b0, 24'h0);
    chk("t4_drop", 64'(drop_count), 64'd1);
    chk("t4_cnt", 64'(pkt_count), 64'd0);
    send_pkt(24'h00002C, 2, 64'hD100, 1, 2'd0, 1'b1, 24'h5);
    drain("t4");

    // Ready throttling.
    rdy_toggle = 1;
    w0 = words_seen;
    send_pkt(24'h000041, 6, 64'hE000, 1, 2'd1, 1'b0, 24'h8);
    drain("t5");
    chk("t5_words", 64'(words_seen - w0), 64'd6);

    // Reset while both sending and receiving.
    send_pkt(24'h000001, 20, 64'hF000, 1, 2'd1, 1'b0, 24'h0);
    up.in_req = 1;
    up.in_pkt_route = 24'h000015;
    repeat (2) @(negedge clk);
    up.in_wr = 1;
    up.in_data = 64'hF100;
    repeat (3) @(negedge clk);
    chk("t6_mid_send", 64'(dn.out_req), 64'd1);
    reset = 1;
    @(posedge clk);
    #1;
    sb.delete();
    up.in_req = 0;
    up.in_wr = 0;
    @(negedge clk);
    chk("t6_outs", 64'({dn.out_req, dn.out_wr, dn.out_bop, dn.out_eop,
        dn.out_bypass, dn.out_neighbor, up.in_ack}), 64'd0);
    chk("t6_data", dn.out_data ^ 64'(dn.out_pkt_route), 64'd0);
    chk("t6_empty", 64'(up.in_empty), 64'd1);
    chk("t6_cnt", 64'(pkt_count), 64'd0);
    reset = 0;
    rdy_toggle = 0;
    send_pkt(24'h000026, 3, 64'h9000, 1, 2'd2, 1'b1, 24'h4);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/packet_buffer_multislot.md
Name: packet_buffer_multislot

Overview:
- Parametrised, multi-slot successor to the single-packet bypass buffer.
- Stores up to SLOTS complete packets in one shared dual-port RAM, partitioned into fixed-size slots.
- Accepts a new packet while an earlier one is being sent, and forwards packets in arrival order.
- Sits between an upstream core/arbiter (req/ack/wr push) and a downstream switch port (req/ack/rdy pull). Decodes per-packet route: neighbor, bypass, shifted route.
- Adds overflow-drop, zero-length discard, and occupancy/drop status.

Parameters:
- DATA_W, 64, packet word width.
- ROUTE_W, 24, route tag width.
- SLOTS, 4, packet slots (power of two, ≥2).
- SLOT_AW, 8, log2 words per slot; DEPTH = 2**SLOT_AW.
- NBR_W, 2, neighbor field = route[NBR_W-1:0].
- BYPASS_BIT, 5, route bit driving out_bypass.
- ROUTE_SHIFT, 3, out_pkt_route = route >> ROUTE_SHIFT, zero-filled.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- in_data, in, DATA_W, write word.
- in_pkt_route, in, ROUTE_W, route tag, sampled on first in_wr.
- in_wr, in, 1, word valid.
- in_req, in, 1, upstream holds high for the whole packet.
- in_ack, out, 1, grant.
- in_empty, out, 1, free slot available and receive side idle.
- out_data, out, DATA_W, read word.
- out_pkt_route, out, ROUTE_W, shifted route.
- out_neighbor, out, NBR_W, destination port.
- out_bypass, out, 1, bypass flag.
- out_wr, out, 1, out_data valid.
- out_bop, out, 1, first word.
- out_eop, out, 1, last word.
- out_req, out, 1, send request.
- out_ack, in, 1, downstream grant.
- out_rdy, in, 1, downstream can take a word.
- pkt_count, out, $clog2(SLOTS+1), committed plus sending packets.
- drop_count, out, 16, saturating drop counter.

Behaviour:
- **Reset:**
  - Both FSMs idle; all slots free; queue empty; counters 0.
  - in_ack, out_req, out_wr, out_bop, out_eop = 0.
  - out_data, out_pkt_route, out_neighbor, out_bypass = 0.
  - in_empty = 1 on the first cycle after reset.
  - Reset mid-packet abandons all content; no partial output.
- **Receive FSM (R_IDLE, R_RECV):**
  - in_empty = R_IDLE && free slot exists.
  - In R_IDLE with in_req && free slot: in_ack=1 combinationally, allocate the lowest free slot, go to R_RECV. If no slot is free, in_ack stays 0 and in_req waits.
  - In R_RECV, in_ack=1. Each in_wr writes address {slot, wlen} and increments wlen. On the first in_wr, capture the route into per-slot metadata.
  - If wlen == DEPTH, further words are not written and the packet is marked overflow.
  - When in_req falls, return to R_IDLE:
    - wlen==0 → slot freed, nothing counted.
    - overflow → slot freed, drop_count+1 (saturating at 0xFFFF).
    - otherwise → {slot, wlen} pushed into the order queue and pkt_count+1.
- **Send FSM (S_IDLE, S_REQ, S_SEND, S_DONE):**
  - S_IDLE → S_REQ when the queue is non-empty; pop head; load route outputs from slot metadata (stable through S_DONE).
  - S_REQ: out_req=1; on out_ack → S_SEND.
  - S_SEND: out_req=1.
    - When out_rdy and rptr<len: issue read of {slot, rptr} and increment rptr.
    - Registered RAM gives 1-cycle latency: out_wr=1 the cycle after each issued read, with out_data valid.
    - out_bop on word 0; out_eop on word len-1; len==1 asserts both.
    - out_rdy low stalls issue only; an already-issued word still appears.
  - After the eop word: → S_DONE with out_req=0. When !out_ack: free slot, pkt_count-1, → S_IDLE.
- **Simultaneous events and ordering:**
  - A receive commit and a send release in the same cycle are both applied; pkt_count is unchanged.
  - A freed slot may be reallocated the following cycle.
  - The RAM read port and write port are always in distinct slots.
  - Packets exit in commit order.
- **Outputs:** out_* control outputs are registered; in_ack and in_empty are combinational from state.

Decomposition:
- Package pb_multislot_pkg:
  - receive/send state encodings;
  - route field helpers (neighbor, bypass, shift) driven by the parameters;
  - DEPTH and count-width localparams.
- Sub-module pb_slot_queue: SLOTS-entry FIFO of {slot index, length} plus free-slot bitmap and lowest-free encoder. The main module instantiates the dual-port RAM directly.

Test Plan:
1. Single 4-word packet, route 0x000023 → out_neighbor=3, out_bypass=1, out_pkt_route=0x000004; 4 out_wr; bop on word0; eop on word3; pkt_count 1→0.
2. Send SLOTS=4 packets back-to-back while out_ack is held low → pkt_count=4 and in_empty=0. A 5th in_req gets no in_ack until the first packet is released; output order is preserved.
3. 1-word packet → single out_wr with out_bop=out_eop=1. in_req pulse with no in_wr → no output, pkt_count stays 0.
4. Packet of DEPTH+3 words → not forwarded, drop_count=1, slot reusable. A following 2-word packet is forwarded intact.
5. out_rdy toggling 1,0,0,1 during a 6-word send → exactly 6 out_wr, data in order, no duplicates or gaps.
6. Reset asserted mid-receive and mid-send → next cycle all outputs 0, in_empty=1, pkt_count=0; a subsequent packet flows normally.
